// File: rtl/sccb_master.sv
// SCCB (OV7670-compatible) three-phase write master with an open-drain SIOD enable.
// Optional ACK checking is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_master #(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          SCCB_FREQ = 100_000,
    parameter logic [7:0]  CAMERA_ID = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sccb_start,
    input  logic [7:0] sccb_sub_addr,
    input  logic [7:0] sccb_data,
    output logic       sccb_ready,
    output logic       sccb_done,
    output logic       sccb_nack,
    output logic       sioc,
    output logic       siod_oe,
    input  logic       siod_in
);

    localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  q, q_nx;
    logic [3:0]  bit_cnt, bit_nx;
    logic [1:0]  byte_cnt, byte_nx;
    logic [23:0] shreg, shreg_nx;
    logic [QW-1:0] qcnt;
    logic        tick;
    logic        accept;
    logic        nack_stop;

    // A request is taken whenever the master reports ready, including the DONE cycle.
    assign accept = sccb_start && ((state == IDLE) || (state == DONE));
    assign tick   = (qcnt == QTR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt <= '0;
        end else if (accept || state == IDLE || state == DONE || tick) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            q        <= q_nx;
            bit_cnt  <= bit_nx;
            byte_cnt <= byte_nx;
            shreg    <= shreg_nx;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q, nack_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nack_q <= 1'b0;
        end else begin
            nack_q <= nack_nx;
        end
    end

    assign nack_stop = nack_q;
    assign sccb_nack = nack_q;

    // The acknowledge is sampled at the SIOC-high sample point of each ninth slot.
    always_comb begin
        nack_nx = nack_q;
        if (accept) begin
            nack_nx = 1'b0;
        end else if (state == BIT && tick && q == 2'd2 && bit_cnt == 4'd8 && siod_in) begin
            nack_nx = 1'b1;
        end
    end
`else
    logic unused_siod_in;
    assign unused_siod_in = siod_in;
    assign nack_stop      = 1'b0;
    assign sccb_nack      = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        q_nx       = q;
        bit_nx     = bit_cnt;
        byte_nx    = byte_cnt;
        shreg_nx   = shreg;
        sioc       = 1'b1;
        siod_oe    = 1'b0;
        sccb_ready = 1'b0;
        sccb_done  = 1'b0;

        case (state)
            IDLE: begin
                sccb_ready = 1'b1;
            end
            START: begin
                siod_oe = (q == 2'd1);
                if (tick) begin
                    if (q == 2'd1) begin
                        state_nx = BIT;
                        q_nx     = 2'd0;
                        bit_nx   = 4'd0;
                        byte_nx  = 2'd0;
                    end else begin
                        q_nx = q + 2'd1;
                    end
                end
            end
            BIT: begin
                sioc    = (q == 2'd1) || (q == 2'd2);
                siod_oe = (bit_cnt != 4'd8) && !shreg[23];
                if (tick) begin
                    q_nx = q + 2'd1;
                    if (q == 2'd3) begin
                        if (bit_cnt == 4'd8) begin
                            bit_nx = 4'd0;
                            if (byte_cnt == 2'd2 || nack_stop) begin
                                state_nx = STOP;
                            end else begin
                                byte_nx = byte_cnt + 2'd1;
                            end
                        end else begin
                            bit_nx   = bit_cnt + 4'd1;
                            shreg_nx = {shreg[22:0], 1'b0};
                        end
                    end
                end
            end
            STOP: begin
                sioc    = (q != 2'd0);
                siod_oe = (q <= 2'd1);
                if (tick) begin
                    q_nx = q + 2'd1;
                    if (q == 2'd3) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                sccb_ready = 1'b1;
                sccb_done  = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (accept) begin
            state_nx = START;
            q_nx     = 2'd0;
            bit_nx   = 4'd0;
            byte_nx  = 2'd0;
            shreg_nx = {CAMERA_ID, sccb_sub_addr, sccb_data};
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master with a bus decoder and an ACKing camera model.
// Exercises the SCCB_ACK_CHECK_EN build when that macro is defined.
module tb_sccb_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       sccb_start;
    logic [7:0] sccb_sub_addr;
    logic [7:0] sccb_data;
    logic       sccb_ready;
    logic       sccb_done;
    logic       sccb_nack;
    logic       sioc;
    logic       siod_oe;
    logic       siod_in;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int c0     = 0;

    // Camera model state: decoded bus bits and the slave ACK drive.
    logic        prev_sioc  = 1'b1;
    logic        prev_oe    = 1'b0;
    int          bitpos     = 0;
    logic [31:0] rx         = '0;
    int          start_cnt  = 0;
    int          stop_cnt   = 0;
    logic [31:0] last_frame = '0;
    int          last_nbits = 0;
    logic        ack_low    = 1'b0;
    int          nack_byte  = -1;

    assign siod_in = ~(siod_oe | ack_low);

    sccb_master #(
        .CLK_FREQ  (400),
        .SCCB_FREQ (100),
        .CAMERA_ID (8'h42)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sccb_start    (sccb_start),
        .sccb_sub_addr (sccb_sub_addr),
        .sccb_data     (sccb_data),
        .sccb_ready    (sccb_ready),
        .sccb_done     (sccb_done),
        .sccb_nack     (sccb_nack),
        .sioc          (sioc),
        .siod_oe       (siod_oe),
        .siod_in       (siod_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bits are taken on SIOC rising edges; the STOP's own rising edge is dropped when the frame closes.
    always @(negedge clk) begin
        if (!prev_sioc && sioc) begin
            rx = {rx[30:0], ~siod_oe};
            bitpos++;
        end
        if (prev_sioc && sioc && !prev_oe && siod_oe) begin
            start_cnt++;
            bitpos  = 0;
            rx      = '0;
            ack_low = 1'b0;
        end
        if (prev_sioc && sioc && prev_oe && !siod_oe) begin
            stop_cnt++;
            last_frame = rx >> 1;
            last_nbits = bitpos - 1;
        end
        if (!sioc) ack_low = (bitpos % 9 == 8) && (bitpos / 9 != nack_byte);
        prev_sioc = sioc;
        prev_oe   = siod_oe;
    end

    function automatic logic [31:0] frame27(input logic [7:0] s, input logic [7:0] d);
        return {5'b0, 8'h42, 1'b1, s, 1'b1, d, 1'b1};
    endfunction

    function automatic logic [31:0] frame18(input logic [7:0] s);
        return {14'b0, 8'h42, 1'b1, s, 1'b1};
    endfunction

    task automatic send(input logic [7:0] s, input logic [7:0] d);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sccb_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("[TB] FAIL ready_timeout: ready=%b required 1", sccb_ready);
        end
        sccb_start    = 1'b1;
        sccb_sub_addr = s;
        sccb_data     = d;
        @(posedge clk);
        #1;
        c0         = cyc;
        sccb_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sccb_done) begin
                ok  = 1'b1;
                lat = cyc - c0;
                break;
            end
        end
        checks++;
        if (!ok) $display("[TB] FAIL done_timeout: done never seen, required within 400 clks");
        else passes++;
    endtask

    task automatic test_reset();
        int s0;
        bit quiet = 1'b1;
        rst = 1'b1; sccb_start = 1'b0; sccb_sub_addr = '0; sccb_data = '0;
        #1;
        checks++; if (sioc !== 1'b1) $display("[TB] FAIL rst_sioc: got %b required 1", sioc); else passes++;
        checks++; if (siod_oe !== 1'b0) $display("[TB] FAIL rst_oe: got %b required 0", siod_oe); else passes++;
        checks++; if (sccb_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b required 1", sccb_ready); else passes++;
        checks++; if (sccb_done !== 1'b0) $display("[TB] FAIL rst_done: got %b required 0", sccb_done); else passes++;
        checks++; if (sccb_nack !== 1'b0) $display("[TB] FAIL rst_nack: got %b required 0", sccb_nack); else passes++;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Abort at slot 3 quarter 0 of the ID byte, where SIOC is low.
        send(8'hA5, 8'h5A);
        repeat (14) @(posedge clk);
        #1;
        checks++; if (sioc !== 1'b0) $display("[TB] FAIL midbit_sioc: got %b required 0", sioc); else passes++;
        s0 = stop_cnt;
        rst = 1'b1;
        #1;
        checks++; if (sioc !== 1'b1) $display("[TB] FAIL abort_sioc: got %b required 1", sioc); else passes++;
        checks++; if (siod_oe !== 1'b0) $display("[TB] FAIL abort_oe: got %b required 0", siod_oe); else passes++;
        checks++; if (sccb_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b required 1", sccb_ready); else passes++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sioc !== 1'b1 || siod_oe !== 1'b0 || sccb_ready !== 1'b1) quiet = 1'b0;
        end
        checks++; if (!quiet) $display("[TB] FAIL post_reset_idle: bus or ready moved, required idle"); else passes++;
        checks++; if (stop_cnt != s0) $display("[TB] FAIL abort_stop: stops=%0d required %0d", stop_cnt, s0); else passes++;
    endtask

    task automatic test_single_write();
        int lat, s0, p0;
        s0 = start_cnt; p0 = stop_cnt;
        send(8'h12, 8'h80);
        wait_done(lat);
        checks++; if (lat < 113 || lat > 115) $display("[TB] FAIL single_latency: got %0d required 114", lat); else passes++;
        checks++; if (sccb_ready !== 1'b1) $display("[TB] FAIL single_ready_at_done: got %b required 1", sccb_ready); else passes++;
        checks++; if (start_cnt != s0 + 1) $display("[TB] FAIL single_start: got %0d required %0d", start_cnt, s0 + 1); else passes++;
        checks++; if (stop_cnt != p0 + 1) $display("[TB] FAIL single_stop: got %0d required %0d", stop_cnt, p0 + 1); else passes++;
        checks++; if (last_nbits != 27) $display("[TB] FAIL single_nbits: got %0d required 27", last_nbits); else passes++;
        checks++; if (last_frame !== frame27(8'h12, 8'h80)) $display("[TB] FAIL single_frame: got %h required %h", last_frame, frame27(8'h12, 8'h80)); else passes++;
        checks++; if (sccb_nack !== 1'b0) $display("[TB] FAIL single_nack: got %b required 0", sccb_nack); else passes++;
        @(negedge clk);
        checks++; if (sccb_done !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b required 0", sccb_done); else passes++;
    endtask

    task automatic test_busy_request();
        int lat, s0;
        s0 = start_cnt;
        send(8'h6B, 8'h0A);
        sccb_sub_addr = 8'hFF; sccb_data = 8'hFF;
        repeat (10) @(negedge clk);
        checks++; if (sccb_ready !== 1'b0) $display("[TB] FAIL busy_ready: got %b required 0", sccb_ready); else passes++;
        sccb_start = 1'b1; sccb_sub_addr = 8'h3A; sccb_data = 8'h04;
        @(negedge clk);
        sccb_start = 1'b0;
        wait_done(lat);
        repeat (20) @(negedge clk);
        checks++; if (start_cnt != s0 + 1) $display("[TB] FAIL busy_frames: got %0d required %0d", start_cnt, s0 + 1); else passes++;
        checks++; if (last_frame !== frame27(8'h6B, 8'h0A)) $display("[TB] FAIL busy_frame: got %h required %h", last_frame, frame27(8'h6B, 8'h0A)); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat, s0;
        bit seen = 1'b0;
        s0 = start_cnt;
        @(negedge clk);
        sccb_start = 1'b1; sccb_sub_addr = 8'h11; sccb_data = 8'h01;
        @(posedge clk);
        #1;
        c0 = cyc;
        sccb_sub_addr = 8'h0C; sccb_data = 8'h00;
        wait_done(lat);
        checks++; if (last_frame !== frame27(8'h11, 8'h01)) $display("[TB] FAIL b2b_frame1: got %h required %h", last_frame, frame27(8'h11, 8'h01)); else passes++;
        @(posedge clk);
        #1;
        c0 = cyc;
        sccb_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (start_cnt == s0 + 2) seen = 1'b1;
        end
        checks++; if (!seen) $display("[TB] FAIL b2b_restart: starts=%0d required %0d", start_cnt, s0 + 2); else passes++;
        wait_done(lat);
        checks++; if (lat < 113 || lat > 115) $display("[TB] FAIL b2b_latency: got %0d required 114", lat); else passes++;
        checks++; if (last_frame !== frame27(8'h0C, 8'h00)) $display("[TB] FAIL b2b_frame2: got %h required %h", last_frame, frame27(8'h0C, 8'h00)); else passes++;
    endtask

    task automatic test_ack_check();
        int lat;
        nack_byte = 1;
        send(8'h12, 8'h34);
        wait_done(lat);
`ifdef SCCB_ACK_CHECK_EN
        checks++; if (sccb_nack !== 1'b1) $display("[TB] FAIL nack_set: got %b required 1", sccb_nack); else passes++;
        checks++; if (last_nbits != 18) $display("[TB] FAIL nack_nbits: got %0d required 18", last_nbits); else passes++;
        checks++; if (last_frame !== frame18(8'h12)) $display("[TB] FAIL nack_frame: got %h required %h", last_frame, frame18(8'h12)); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (sccb_nack !== 1'b1) $display("[TB] FAIL nack_sticky: got %b required 1", sccb_nack); else passes++;
        nack_byte = -1;
        send(8'h20, 8'h7F);
        @(negedge clk);
        checks++; if (sccb_nack !== 1'b0) $display("[TB] FAIL nack_clear: got %b required 0", sccb_nack); else passes++;
        wait_done(lat);
        checks++; if (last_nbits != 27) $display("[TB] FAIL ack_full_nbits: got %0d required 27", last_nbits); else passes++;
`else
        checks++; if (sccb_nack !== 1'b0) $display("[TB] FAIL nack_tied: got %b required 0", sccb_nack); else passes++;
        checks++; if (last_nbits != 27) $display("[TB] FAIL noack_nbits: got %0d required 27", last_nbits); else passes++;
        checks++; if (last_frame !== frame27(8'h12, 8'h34)) $display("[TB] FAIL noack_frame: got %h required %h", last_frame, frame27(8'h12, 8'h34)); else passes++;
        nack_byte = -1;
`endif
        checks++; if (sccb_nack !== 1'b0) $display("[TB] FAIL final_nack: got %b required 0", sccb_nack); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_busy_request();
        test_back_to_back();
        test_ack_check();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
